// File: rtl/esp_uart2_pkg.sv
// Shared encodings and helpers for the esp_uart2 UART and its FIFOs.
package esp_uart2_pkg;

    // Smallest usable bit period divisor; anything lower is clamped up to it.
    localparam logic [15:0] MIN_BAUD_DIV = 16'd3;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_BREAK,
        TX_GUARD
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit that makes the total count of ones even (or odd).
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the oldest entry.
module uart_fifo
    import esp_uart2_pkg::*;
#(
    parameter int AW     = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = level[AW];
    assign do_rd = rd && !empty;
    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign do_wr = wr && (!full || do_rd);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers on accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/esp_uart2.sv
// UART with TX/RX FIFOs, runtime baud divisor, parity, CTS-gated TX and RTS threshold.
module esp_uart2
    import esp_uart2_pkg::*;
#(
    parameter int TXFIFO_AW  = 4,
    parameter int RXFIFO_AW  = 5,
    parameter int RTS_MARGIN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        baud_div,
    input  logic [1:0]         parity_mode,
    input  logic               flow_ctrl_en,
    input  logic [7:0]         tx_data,
    input  logic               tx_wr,
    input  logic               tx_break,
    output logic               tx_full,
    output logic               tx_idle,
    output logic [7:0]         rx_data,
    input  logic               rx_rd,
    output logic               rx_not_empty,
    output logic [RXFIFO_AW:0] rx_level,
    output logic               rx_overflow,
    output logic               rx_framing_error,
    output logic               rx_parity_error,
    output logic               rx_break,
    input  logic               uart_rxd,
    output logic               uart_txd,
    input  logic               uart_cts,
    output logic               uart_rts
);

    localparam int RX_DEPTH = 1 << RXFIFO_AW;
    localparam logic [RXFIFO_AW:0] RTS_THRESH = (RXFIFO_AW + 1)'(RX_DEPTH - RTS_MARGIN);

    function automatic logic [15:0] sat_div(input logic [15:0] d);
        return (d < MIN_BAUD_DIV) ? MIN_BAUD_DIV : d;
    endfunction

    // Synchronisers: rxd_p2 is the previous synchronised sample, used for edge detection.
    logic rxd_p0, rxd_p1, rxd_p2;
    logic cts_p0, cts_p1;

    // TX side
    logic [7:0]       tx_rdata;
    logic             tx_empty;
    logic             tx_fifo_full;
    logic [TXFIFO_AW:0] tx_level;
    tx_state_e        tx_state;
    logic [15:0]      tx_div;
    logic [15:0]      tx_cnt;
    logic [1:0]       tx_pmode;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_par;
    logic             tx_bit_end;
    logic             tx_can_start;
    logic             tx_decide;
    logic             tx_pop;

    // RX side
    logic [7:0]       rx_rdata;
    logic             rx_empty;
    logic             rx_full;
    rx_state_e        rx_state;
    logic [15:0]      rx_div;
    logic [15:0]      rx_cnt;
    logic [1:0]       rx_pmode;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_par_bit;
    logic             rx_bit_end;
    logic             rx_half;
    logic             rx_fall;
    logic             push_p0, perr_p0, brk_p0, ferr_p0;

    uart_fifo #(.AW(TXFIFO_AW), .DATA_W(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (tx_wr && !tx_fifo_full),
        .wdata (tx_data),
        .rd    (tx_pop),
        .rdata (tx_rdata),
        .empty (tx_empty),
        .full  (tx_fifo_full),
        .level (tx_level)
    );

    uart_fifo #(.AW(RXFIFO_AW), .DATA_W(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (push_p0),
        .wdata (rx_shift),
        .rd    (rx_rd),
        .rdata (rx_rdata),
        .empty (rx_empty),
        .full  (rx_full),
        .level (rx_level)
    );

    assign tx_full      = tx_fifo_full;
    assign tx_idle      = (tx_level == '0) && (tx_state == TX_IDLE);
    assign rx_not_empty = !rx_empty;

    // Double-flop both asynchronous pins; idle line level is high, CTS defaults to ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
            cts_p0 <= 1'b0;
            cts_p1 <= 1'b0;
        end else begin
            rxd_p0 <= uart_rxd;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
            cts_p0 <= uart_cts;
            cts_p1 <= cts_p0;
        end
    end

    // The end of a stop bit makes the same start/break decision as IDLE, giving back-to-back frames.
    assign tx_bit_end   = (tx_cnt == tx_div);
    assign tx_can_start = !tx_empty && !tx_break && !(flow_ctrl_en && cts_p1);
    assign tx_decide    = (tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end);
    assign tx_pop       = tx_decide && tx_can_start;

    // TX state machine; uart_txd is registered and is forced high by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            uart_txd <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= MIN_BAUD_DIV;
            tx_pmode <= PAR_NONE;
            tx_bit   <= '0;
        end else if (tx_decide) begin
            tx_cnt <= '0;
            if (tx_break) begin
                tx_state <= TX_BREAK;
                uart_txd <= 1'b0;
                tx_div   <= sat_div(baud_div);
            end else if (tx_can_start) begin
                tx_state <= TX_START;
                uart_txd <= 1'b0;
                tx_div   <= sat_div(baud_div);
                tx_pmode <= parity_mode;
                tx_bit   <= '0;
            end else begin
                tx_state <= TX_IDLE;
                uart_txd <= 1'b1;
            end
        end else begin
            case (tx_state)
                TX_BREAK: begin
                    tx_cnt <= '0;
                    if (!tx_break) begin
                        tx_state <= TX_GUARD;
                        uart_txd <= 1'b1;
                    end
                end
                default: begin
                    if (!tx_bit_end) begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end else begin
                        tx_cnt <= '0;
                        case (tx_state)
                            TX_START: begin
                                tx_state <= TX_DATA;
                                uart_txd <= tx_shift[0];
                            end
                            TX_DATA: begin
                                if (tx_bit == 3'd7) begin
                                    if (parity_enabled(tx_pmode)) begin
                                        tx_state <= TX_PARITY;
                                        uart_txd <= tx_par;
                                    end else begin
                                        tx_state <= TX_STOP;
                                        uart_txd <= 1'b1;
                                    end
                                end else begin
                                    tx_bit   <= tx_bit + 3'd1;
                                    uart_txd <= tx_shift[1];
                                end
                            end
                            TX_PARITY: begin
                                tx_state <= TX_STOP;
                                uart_txd <= 1'b1;
                            end
                            default: begin
                                tx_state <= TX_IDLE;
                                uart_txd <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // TX data path: load the byte and its parity at pop, shift right after each data bit.
    always_ff @(posedge clk) begin
        if (tx_pop) begin
            tx_shift <= tx_rdata;
            tx_par   <= parity_bit(tx_rdata, parity_mode);
        end else if ((tx_state == TX_DATA) && tx_bit_end) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

    // START samples at (div+1)/2 clocks, later bits every div+1 clocks.
    assign rx_bit_end = (rx_cnt == rx_div);
    assign rx_half    = (rx_cnt == ((rx_div >> 1) + {15'd0, rx_div[0]}));
    assign rx_fall    = rxd_p2 && !rxd_p1;

    // RX state machine; stop-bit outcomes are staged in *_p0 for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= MIN_BAUD_DIV;
            rx_pmode <= PAR_NONE;
            rx_bit   <= '0;
            push_p0  <= 1'b0;
            perr_p0  <= 1'b0;
            brk_p0   <= 1'b0;
            ferr_p0  <= 1'b0;
        end else begin
            push_p0 <= 1'b0;
            perr_p0 <= 1'b0;
            brk_p0  <= 1'b0;
            ferr_p0 <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_div   <= sat_div(baud_div);
                        rx_pmode <= parity_mode;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        // A line already back high means the falling edge was a glitch.
                        rx_state <= rxd_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rx_bit == 3'd7) begin
                            rx_state <= parity_enabled(rx_pmode) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rxd_p1) begin
                            rx_state <= RX_IDLE;
                            push_p0  <= 1'b1;
                            perr_p0  <= parity_enabled(rx_pmode) &&
                                        (rx_par_bit != parity_bit(rx_shift, rx_pmode));
                        end else begin
                            rx_state <= RX_WAIT_HIGH;
                            if ((rx_shift == 8'h00) && !rx_par_bit) brk_p0 <= 1'b1;
                            else                                    ferr_p0 <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    if (rxd_p1) rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // RX data path: shift data bits in LSB first and capture the parity bit.
    always_ff @(posedge clk) begin
        if (rx_state == RX_START) begin
            rx_par_bit <= 1'b0;
        end else if ((rx_state == RX_DATA) && rx_bit_end) begin
            rx_shift <= {rxd_p1, rx_shift[7:1]};
        end else if ((rx_state == RX_PARITY) && rx_bit_end) begin
            rx_par_bit <= rxd_p1;
        end
    end

    // Event pulses, RTS compare and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow      <= 1'b0;
            rx_framing_error <= 1'b0;
            rx_parity_error  <= 1'b0;
            rx_break         <= 1'b0;
            uart_rts         <= 1'b0;
            rx_data          <= 8'h00;
        end else begin
            rx_overflow      <= push_p0 && rx_full && !rx_rd;
            rx_framing_error <= ferr_p0;
            rx_parity_error  <= push_p0 && perr_p0;
            rx_break         <= brk_p0;
            uart_rts         <= (rx_level >= RTS_THRESH);
            if (rx_rd && !rx_empty) rx_data <= rx_rdata;
        end
    end

endmodule
